// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH independent integer dividers of clk_in. Each channel has a
// runtime ratio that is swapped in only at a period boundary (or on align). Enable and
// disable never shorten a pulse. A per-channel rise strobe lets clk_in logic use
// clock enables instead of the divided clocks.
module multi_clock_divider #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DIV_W   = 4,
    parameter int unsigned DEF_DIV = 8
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_CH*DIV_W-1:0] div_ratio,
    input  logic                    div_load,
    input  logic                    align,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       rise_stb,
    output logic                    busy
);

    localparam int unsigned HW = DIV_W + 1;

    logic              busy_q;
    logic              load_ok;
    logic [NUM_CH-1:0] pend_vec;

    // A load is only accepted while no earlier ratio is still waiting to be applied.
    assign load_ok = div_load & ~busy_q;
    assign busy    = busy_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] ratio_q;
        logic [DIV_W-1:0] pend_ratio_q;
        logic             pend_q;
        logic             run_q;
        logic             clk_q;
        logic             rise_q;
        logic [DIV_W-1:0] field;
        logic [DIV_W-1:0] field_san;
        logic [HW-1:0]    high_len;
        logic             wrap;

        assign field     = div_ratio[k*DIV_W +: DIV_W];
        // Ratios 0 and 1 cannot form a clock; treat them as divide-by-2.
        assign field_san = (field < DIV_W'(2)) ? DIV_W'(2) : field;
        // Computed one bit wider so the all-ones ratio does not overflow.
        assign high_len  = ({1'b0, ratio_q} + HW'(1)) >> 1;
        assign wrap      = (cnt_q == ratio_q - DIV_W'(1));

        assign clk_out[k]  = clk_q;
        assign rise_stb[k] = rise_q;
        assign pend_vec[k] = pend_q;

        // Channel counter, ratio swap, start/stop and align handling.
        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q        <= '0;
                ratio_q      <= DIV_W'(DEF_DIV);
                pend_ratio_q <= '0;
                pend_q       <= 1'b0;
                run_q        <= 1'b0;
                clk_q        <= 1'b0;
                rise_q       <= 1'b0;
            end else begin
                if (!run_q) begin
                    // Stopped: hold low; start counting from zero on the next edge.
                    cnt_q  <= '0;
                    clk_q  <= 1'b0;
                    rise_q <= 1'b0;
                    if (enable) begin
                        run_q <= 1'b1;
                        if (pend_q) begin
                            ratio_q <= pend_ratio_q;
                            pend_q  <= 1'b0;
                        end
                    end
                end else if (align) begin
                    // Force a low cycle so every channel rises together on the next edge.
                    cnt_q  <= '0;
                    clk_q  <= 1'b0;
                    rise_q <= 1'b0;
                    if (pend_q) begin
                        ratio_q <= pend_ratio_q;
                        pend_q  <= 1'b0;
                    end
                end else begin
                    clk_q  <= ({1'b0, cnt_q} < high_len);
                    rise_q <= (cnt_q == '0);
                    if (wrap) begin
                        cnt_q <= '0;
                        if (pend_q) begin
                            ratio_q <= pend_ratio_q;
                            pend_q  <= 1'b0;
                        end
                        if (!enable) begin
                            run_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                // Capture wins over the apply above when both hit the same edge.
                if (load_ok) begin
                    pend_ratio_q <= field_san;
                    pend_q       <= 1'b1;
                end
            end
        end
    end

    // busy lags the pending flags by one edge so it comes straight from a flop.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= |pend_vec;
        end
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Scoreboard bench for multi_clock_divider (NUM_CH=2, DIV_W=4, DEF_DIV=8).
// Directed phases push expected (high cycles, period cycles) records per channel; a
// monitor measures each completed period between rise_stb pulses and compares.
module tb_multi_clock_divider;

    logic       clk_in;
    logic       rst_n;
    logic       enable;
    logic [7:0] div_ratio;
    logic       div_load;
    logic       align;
    logic [1:0] clk_out;
    logic [1:0] rise_stb;
    logic       busy;

    typedef struct {
        int hi;
        int per;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];
    int   checks    = 0;
    int   errors    = 0;
    int   flush_req = 0;

    multi_clock_divider #(
        .NUM_CH (2),
        .DIV_W  (4),
        .DEF_DIV(8)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .enable   (enable),
        .div_ratio(div_ratio),
        .div_load (div_load),
        .align    (align),
        .clk_out  (clk_out),
        .rise_stb (rise_stb),
        .busy     (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic push(input int k, input int hi, input int per, input int n);
        rec_t r;
        r.hi  = hi;
        r.per = per;
        for (int i = 0; i < n; i++) begin
            if (k == 0) q0.push_back(r);
            else q1.push_back(r);
        end
    endtask

    task automatic flush();
        flush_req++;
    endtask

    // Returns at the negedge where rise_stb[k] is seen (channel cnt is then 1).
    task automatic wait_rise(input int k);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk_in);
            if (rise_stb[k]) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_rise ch%0d: no rise_stb within 64 cycles", k);
        end
    endtask

    task automatic end_phase(input string name);
        check({name, " q0 left"}, q0.size(), 0);
        check({name, " q1 left"}, q1.size(), 0);
        q0.delete();
        q1.delete();
    endtask

    // Monitor: period = rise to next rise; high = clk_out high cycles within it.
    initial begin
        int         seen;
        bit         have[2];
        int         hi[2];
        int         per[2];
        logic [1:0] prev;
        rec_t       r;
        bit         got;
        seen = 0;
        have[0] = 1'b0;
        have[1] = 1'b0;
        prev = 2'b00;
        forever begin
            @(negedge clk_in);
            if (flush_req != seen) begin
                seen    = flush_req;
                have[0] = 1'b0;
                have[1] = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (rise_stb[k]) begin
                    checks++;
                    if (!(clk_out[k] && !prev[k])) begin
                        errors++;
                        $display("FAIL rise_align ch%0d: clk_out %b prev %b, need 1 after 0",
                                 k, clk_out[k], prev[k]);
                    end
                    if (have[k]) begin
                        got = 1'b0;
                        if (k == 0 && q0.size() > 0) begin
                            r = q0.pop_front();
                            got = 1'b1;
                        end else if (k == 1 && q1.size() > 0) begin
                            r = q1.pop_front();
                            got = 1'b1;
                        end
                        if (got) begin
                            checks++;
                            if (hi[k] != r.hi || per[k] != r.per) begin
                                errors++;
                                $display("FAIL period ch%0d: high %0d period %0d, need high %0d period %0d",
                                         k, hi[k], per[k], r.hi, r.per);
                            end
                        end
                    end
                    have[k] = 1'b1;
                    hi[k]   = 1;
                    per[k]  = 1;
                end else if (have[k]) begin
                    per[k]++;
                    if (clk_out[k]) hi[k]++;
                end
            end
            prev = clk_out;
        end
    end

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        div_ratio = 8'h00;
        div_load  = 1'b0;
        align     = 1'b0;

        // Reset state and enable latency with default ratio 8.
        step(3);
        check("reset clk_out", clk_out, 2'b00);
        check("reset rise_stb", rise_stb, 2'b00);
        check("reset busy", busy, 1'b0);
        rst_n = 1'b1;
        step(2);
        check("stopped clk_out", clk_out, 2'b00);
        flush();
        push(0, 4, 8, 3);
        push(1, 4, 8, 3);
        enable = 1'b1;
        step(1);
        check("enable latency low", clk_out, 2'b00);
        step(1);
        check("enable latency clk_out", clk_out, 2'b11);
        check("enable latency rise_stb", rise_stb, 2'b11);
        step(30);
        end_phase("defaults");

        // Mid-period load of ch0=3, ch1=5: old 8-cycle period completes first.
        flush();
        push(0, 4, 8, 1);
        push(0, 2, 3, 3);
        push(1, 4, 8, 1);
        push(1, 3, 5, 3);
        wait_rise(0);
        div_ratio = {4'd5, 4'd3};
        div_load  = 1'b1;
        step(1);
        div_load = 1'b0;
        step(1);
        check("load busy high", busy, 1'b1);
        step(7);
        check("load busy low", busy, 1'b0);
        step(20);
        end_phase("load 3/5");

        // Ratios 0 and 1 sanitise to 2; a load while busy is dropped.
        wait_rise(1);
        div_ratio = {4'd1, 4'd0};
        div_load  = 1'b1;
        step(1);
        div_load = 1'b0;
        step(1);
        check("busy before 2nd load", busy, 1'b1);
        div_ratio = {4'd7, 4'd7};
        div_load  = 1'b1;
        step(1);
        div_load = 1'b0;
        step(1);
        flush();
        push(0, 1, 2, 6);
        push(1, 1, 2, 6);
        step(20);
        check("sanitise busy low", busy, 1'b0);
        end_phase("load 0/1");

        // Back to 8 on both, phase-lock, then stop at cnt 1 and restart.
        div_ratio = {4'd8, 4'd8};
        div_load  = 1'b1;
        step(1);
        div_load = 1'b0;
        step(12);
        align = 1'b1;
        step(1);
        align = 1'b0;
        step(2);
        flush();
        push(0, 4, 22, 1);
        push(0, 4, 8, 2);
        push(1, 4, 22, 1);
        push(1, 4, 8, 2);
        wait_rise(0);
        enable = 1'b0;
        step(20);
        check("stopped after disable", clk_out, 2'b00);
        check("stopped rise_stb", rise_stb, 2'b00);
        enable = 1'b1;
        step(1);
        check("reenable latency low", clk_out, 2'b00);
        step(1);
        check("reenable clk_out", clk_out, 2'b11);
        check("reenable rise_stb", rise_stb, 2'b11);
        step(20);
        end_phase("disable");

        // ch0=4, ch1=6 free running, then align truncates ch1's high phase.
        div_ratio = {4'd6, 4'd4};
        div_load  = 1'b1;
        step(1);
        div_load = 1'b0;
        step(12);
        wait_rise(1);
        step(1);
        flush();
        push(0, 2, 4, 3);
        push(1, 3, 6, 3);
        align = 1'b1;
        step(1);
        align = 1'b0;
        check("align low clk_out", clk_out, 2'b00);
        check("align low rise_stb", rise_stb, 2'b00);
        step(1);
        check("align rise clk_out", clk_out, 2'b11);
        check("align rise rise_stb", rise_stb, 2'b11);
        step(25);
        end_phase("align");

        // Asynchronous reset in ch1's high phase with a load pending.
        wait_rise(1);
        div_ratio = {4'd3, 4'd3};
        div_load  = 1'b1;
        step(1);
        div_load = 1'b0;
        step(1);
        check("pre-reset busy", busy, 1'b1);
        check("pre-reset ch1 high", clk_out[1], 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset clk_out", clk_out, 2'b00);
        check("async reset rise_stb", rise_stb, 2'b00);
        check("async reset busy", busy, 1'b0);
        step(2);
        flush();
        push(0, 4, 8, 2);
        push(1, 4, 8, 2);
        rst_n = 1'b1;
        step(30);
        check("post-reset busy", busy, 1'b0);
        end_phase("reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
